// File: rtl/kamacore_hazard_if.sv
// rtl/kamacore_hazard_if.sv - hazard-detect inputs and stall/flush controls between pipeline and sequencer
interface kamacore_hazard_if #(
   parameter int REG_ADDR_WIDTH    = 4,
   parameter int STALL_COUNT_WIDTH = 16
) ();
   logic [REG_ADDR_WIDTH-1:0]    ID_register_a;
   logic [REG_ADDR_WIDTH-1:0]    ID_register_b;
   logic                         ID_uses_a;
   logic                         ID_uses_b;
   logic [REG_ADDR_WIDTH-1:0]    EX_destination_register;
   logic                         EX_control_mem_read;
   logic                         EX_branch_taken;
   logic                         MEM_mem_req;
   logic                         MEM_mem_ack;
   logic                         stall_PC;
   logic                         stall_IF_ID;
   logic                         stall_ID_EX;
   logic                         stall_EX_MEM;
   logic                         flush_IF_ID;
   logic                         flush_ID_EX;
   logic                         flush_MEM_WB;
   logic                         fault;
   logic [STALL_COUNT_WIDTH-1:0] stall_cycles;

   modport master (
      output ID_register_a, ID_register_b, ID_uses_a, ID_uses_b,
             EX_destination_register, EX_control_mem_read, EX_branch_taken,
             MEM_mem_req, MEM_mem_ack,
      input  stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
             flush_IF_ID, flush_ID_EX, flush_MEM_WB, fault, stall_cycles
   );

   modport slave (
      input  ID_register_a, ID_register_b, ID_uses_a, ID_uses_b,
             EX_destination_register, EX_control_mem_read, EX_branch_taken,
             MEM_mem_req, MEM_mem_ack,
      output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
             flush_IF_ID, flush_ID_EX, flush_MEM_WB, fault, stall_cycles
   );
endinterface

// File: rtl/kamacore_hazard_controller.sv
// rtl/kamacore_hazard_controller.sv - kamacore 5-stage pipeline sequencer: load-use, branch flush, memory wait and timeout fault
module kamacore_hazard_controller #(
   parameter int REG_ADDR_WIDTH    = 4,
   parameter int MEM_TIMEOUT       = 64,
   parameter int TIMEOUT_WIDTH     = 8,
   parameter int STALL_COUNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   kamacore_hazard_if.slave hz
);
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIM = TIMEOUT_WIDTH'(MEM_TIMEOUT);

   state_t                       state_q, state_d;
   logic [TIMEOUT_WIDTH-1:0]     wait_cnt_q, wait_cnt_d;
   logic [STALL_COUNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

   logic mem_wait;
   logic load_use;
   logic mem_stall;
   logic eval_hazards;
   logic branch_flush;
   logic load_use_stall;
   logic stall_pc_int;

   assign mem_wait = hz.MEM_mem_req & ~hz.MEM_mem_ack;

   // r0 is hardwired zero, so a load targeting it can never feed the ID instruction
   assign load_use = hz.EX_control_mem_read
                   & (hz.EX_destination_register != '0)
                   & ((hz.ID_uses_a & (hz.ID_register_a == hz.EX_destination_register))
                    | (hz.ID_uses_b & (hz.ID_register_b == hz.EX_destination_register)));

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_stall    = 1'b0;
      eval_hazards = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_wait) begin
               mem_stall  = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = TIMEOUT_WIDTH'(1);
            end else begin
               eval_hazards = 1'b1;
            end
         end
         MEM_WAIT: begin
            // a dropped request without ack releases the pipeline just like an ack
            if (mem_wait) begin
               mem_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
               if (wait_cnt_d == TIMEOUT_LIM) begin
                  state_d = FAULT;
               end
            end else begin
               state_d      = RUN;
               wait_cnt_d   = '0;
               eval_hazards = 1'b1;
            end
         end
         FAULT: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // a taken branch squashes the ID instruction, which makes its load-use moot
   assign branch_flush   = eval_hazards & hz.EX_branch_taken;
   assign load_use_stall = eval_hazards & ~hz.EX_branch_taken & load_use;
   assign stall_pc_int   = ~reset & (mem_stall | load_use_stall);

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_pc_int && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + STALL_COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.stall_PC     = stall_pc_int;
   assign hz.stall_IF_ID  = stall_pc_int;
   assign hz.stall_ID_EX  = ~reset & mem_stall;
   assign hz.stall_EX_MEM = ~reset & mem_stall;
   assign hz.flush_IF_ID  = ~reset & branch_flush;
   assign hz.flush_ID_EX  = ~reset & (branch_flush | load_use_stall);
   assign hz.flush_MEM_WB = ~reset & mem_stall;
   assign hz.fault        = ~reset & (state_q == FAULT);
   assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_kamacore_hazard_controller.sv
// tb/tb_kamacore_hazard_controller.sv - directed bench: default instance plus a MEM_TIMEOUT=4 / 4-bit counter instance
module tb_kamacore_hazard_controller;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   kamacore_hazard_if #(.REG_ADDR_WIDTH(4), .STALL_COUNT_WIDTH(16)) ifa ();
   kamacore_hazard_if #(.REG_ADDR_WIDTH(4), .STALL_COUNT_WIDTH(4))  ifb ();

   kamacore_hazard_controller #(
      .REG_ADDR_WIDTH(4), .MEM_TIMEOUT(64), .TIMEOUT_WIDTH(8), .STALL_COUNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .reset(reset), .hz(ifa)
   );

   kamacore_hazard_controller #(
      .REG_ADDR_WIDTH(4), .MEM_TIMEOUT(4), .TIMEOUT_WIDTH(8), .STALL_COUNT_WIDTH(4)
   ) dut_b (
      .clk(clk), .reset(reset), .hz(ifb)
   );

   // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, flush_MEM_WB, fault}
   logic [7:0] ctl_a;
   logic [7:0] ctl_b;
   assign ctl_a = {ifa.stall_PC, ifa.stall_IF_ID, ifa.stall_ID_EX, ifa.stall_EX_MEM,
                   ifa.flush_IF_ID, ifa.flush_ID_EX, ifa.flush_MEM_WB, ifa.fault};
   assign ctl_b = {ifb.stall_PC, ifb.stall_IF_ID, ifb.stall_ID_EX, ifb.stall_EX_MEM,
                   ifb.flush_IF_ID, ifb.flush_ID_EX, ifb.flush_MEM_WB, ifb.fault};

   localparam logic [7:0] C_NONE  = 8'b0000_0000;
   localparam logic [7:0] C_LU    = 8'b1100_0100;
   localparam logic [7:0] C_BR    = 8'b0000_1100;
   localparam logic [7:0] C_FULL  = 8'b1111_0010;
   localparam logic [7:0] C_FAULT = 8'b1111_0011;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ra, input logic ua, input logic [3:0] rb, input logic ub,
                        input logic [3:0] dest, input logic mr, input logic br,
                        input logic req, input logic ack);
      ifa.ID_register_a = ra;  ifb.ID_register_a = ra;
      ifa.ID_uses_a     = ua;  ifb.ID_uses_a     = ua;
      ifa.ID_register_b = rb;  ifb.ID_register_b = rb;
      ifa.ID_uses_b     = ub;  ifb.ID_uses_b     = ub;
      ifa.EX_destination_register = dest;  ifb.EX_destination_register = dest;
      ifa.EX_control_mem_read     = mr;    ifb.EX_control_mem_read     = mr;
      ifa.EX_branch_taken         = br;    ifb.EX_branch_taken         = br;
      ifa.MEM_mem_req             = req;   ifb.MEM_mem_req             = req;
      ifa.MEM_mem_ack             = ack;   ifb.MEM_mem_ack             = ack;
      #1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;

      // load-use present while reset is high: every control stays low
      drive(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset_ctl_a", 32'(ctl_a), 32'(C_NONE));
      chk("reset_ctl_b", 32'(ctl_b), 32'(C_NONE));
      chk("reset_cnt_a", 32'(ifa.stall_cycles), 32'd0);
      cyc();
      reset = 1'b0;
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_ctl_a", 32'(ctl_a), 32'(C_NONE));
      cyc();

      // load-use on reg a: one bubble
      drive(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_a_ctl_a", 32'(ctl_a), 32'(C_LU));
      chk("lu_a_ctl_b", 32'(ctl_b), 32'(C_LU));
      cyc();
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_clear_ctl_a", 32'(ctl_a), 32'(C_NONE));
      chk("lu_cnt_a", 32'(ifa.stall_cycles), 32'd1);
      cyc();

      drive(4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_r0_ctl_a", 32'(ctl_a), 32'(C_NONE));
      cyc();
      drive(4'd5, 1'b0, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_unused_a_ctl_a", 32'(ctl_a), 32'(C_NONE));
      cyc();
      drive(4'd5, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_b_ctl_a", 32'(ctl_a), 32'(C_LU));
      cyc();
      drive(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("br_lu_ctl_a", 32'(ctl_a), 32'(C_BR));
      cyc();

      // single-cycle memory access
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mem_1cyc_ctl_a", 32'(ctl_a), 32'(C_NONE));
      chk("pre_mem_cnt_a", 32'(ifa.stall_cycles), 32'd2);
      cyc();

      // memory wait: ack on the 4th cycle, with a taken branch evaluated that cycle
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("memwait_ctl_a_%0d", i), 32'(ctl_a), 32'(C_FULL));
         cyc();
      end
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mem_ack_ctl_a", 32'(ctl_a), 32'(C_BR));
      chk("mem_ack_cnt_a", 32'(ifa.stall_cycles), 32'd5);
      cyc();

      // request dropped without ack releases the wait
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drop_wait_ctl_a", 32'(ctl_a), 32'(C_FULL));
      cyc();
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("drop_rel_ctl_a", 32'(ctl_a), 32'(C_NONE));
      cyc();

      // timeout on the MEM_TIMEOUT=4 instance
      for (int i = 0; i < 4; i++) begin
         drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("to_wait_ctl_b_%0d", i), 32'(ctl_b), 32'(C_FULL));
         cyc();
      end
      chk("to_fault_ctl_b", 32'(ctl_b), 32'(C_FAULT));
      chk("to_wait_ctl_a", 32'(ctl_a), 32'(C_FULL));
      chk("to_cnt_b", 32'(ifb.stall_cycles), 32'd10);
      cyc();
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fault_sticky_ctl_b", 32'(ctl_b), 32'(C_FAULT));
      chk("rel_ctl_a", 32'(ctl_a), 32'(C_NONE));
      chk("rel_cnt_a", 32'(ifa.stall_cycles), 32'd11);
      cyc();

      // 4-bit counter saturates instead of wrapping (32 increments would wrap to 0)
      repeat (20) cyc();
      chk("sat_cnt_b", 32'(ifb.stall_cycles), 32'd15);
      chk("sat_cnt_a", 32'(ifa.stall_cycles), 32'd11);
      chk("sat_ctl_b", 32'(ctl_b), 32'(C_FAULT));

      // async reset between edges while in FAULT
      #2;
      reset = 1'b1;
      #1;
      chk("arst_fault_ctl_b", 32'(ctl_b), 32'(C_NONE));
      chk("arst_fault_cnt_b", 32'(ifb.stall_cycles), 32'd0);
      chk("arst_fault_cnt_a", 32'(ifa.stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_arst_ctl_b", 32'(ctl_b), 32'(C_NONE));
      cyc();

      // async reset in the middle of a memory wait
      drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mw2_ctl_a_0", 32'(ctl_a), 32'(C_FULL));
      cyc();
      chk("mw2_ctl_a_1", 32'(ctl_a), 32'(C_FULL));
      cyc();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_mw_ctl_a", 32'(ctl_a), 32'(C_NONE));
      chk("arst_mw_ctl_b", 32'(ctl_b), 32'(C_NONE));
      chk("arst_mw_cnt_b", 32'(ifb.stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // a fresh wait count after release: fault exactly after 4 stalled cycles
      for (int i = 0; i < 4; i++) begin
         drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("rerun_ctl_b_%0d", i), 32'(ctl_b), 32'(C_FULL));
         cyc();
      end
      chk("rerun_fault_ctl_b", 32'(ctl_b), 32'(C_FAULT));
      chk("rerun_cnt_b", 32'(ifb.stall_cycles), 32'd4);
      chk("rerun_cnt_a", 32'(ifa.stall_cycles), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
